// File: rtl/mobius_pkg.sv
// Shared types and elaboration helpers for the sequential Mobius transform.
// Stage k pairs index i with index i-m where m = N >> (k+1).
package mobius_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int stage_mask(input int n, input int k);
        return n >> (k + 1);
    endfunction

    // Width of the step counter; a single-step schedule still needs one bit.
    function automatic int cnt_width(input int log2n, input int s);
        int w;
        w = $clog2(log2n / s);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mobius_stage_dyn.sv
// One GF(2) Mobius butterfly stage whose stage index is chosen at run time.
// All LOG2_N fixed stages are built side by side and stage_k picks one.
module mobius_stage_dyn
    import mobius_pkg::*;
#(
    parameter int N      = 512,
    parameter int LOG2_N = 9,
    parameter int KW     = (LOG2_N > 1) ? $clog2(LOG2_N) : 1
) (
    input  logic [KW-1:0] stage_k,
    input  logic [0:N-1]  d_i,
    output logic [0:N-1]  d_o
);

    logic [0:N-1] stage_out [0:LOG2_N-1];

    for (genvar k = 0; k < LOG2_N; k++) begin : g_k
        localparam int M = stage_mask(N, k);
        logic [0:N-1] hi;
        for (genvar i = 0; i < N; i++) begin : g_i
            assign hi[i] = ((i & M) != 0);
        end
        // On an ascending vector, >> moves bit i-M into position i.
        assign stage_out[k] = d_i ^ ((d_i >> M) & hi);
    end

    always_comb begin
        d_o = d_i;
        if ({1'b0, stage_k} < (KW + 1)'(LOG2_N)) begin
            d_o = stage_out[stage_k];
        end
    end

endmodule

// File: rtl/mobius_seq_inv.sv
// Iterative Mobius transform (ANF -> truth table) applying S stages per clock.
// Handshake: a transfer happens on any rising edge where valid && ready.
module mobius_seq_inv
    import mobius_pkg::*;
#(
    parameter int N      = 512,
    parameter int LOG2_N = 9,
    parameter int S      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:N-1] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:N-1] out_data,
    output logic         busy
);

    localparam int STEPS = LOG2_N / S;
    localparam int CW    = cnt_width(LOG2_N, S);
    localparam int KW    = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

    if (N != (1 << LOG2_N)) begin : g_bad_n
        $error("mobius_seq_inv: N must equal 2**LOG2_N");
    end
    if ((S < 1) || ((LOG2_N % S) != 0)) begin : g_bad_s
        $error("mobius_seq_inv: S must divide LOG2_N");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:N-1]  data_q, data_d;
    logic [0:N-1]  chain [0:S];
    logic          accept;

    assign chain[0] = data_q;

    // Instance t handles stage cnt*S + t within the current step.
    for (genvar t = 0; t < S; t++) begin : g_stage
        logic [KW-1:0] k_t;
        assign k_t = KW'(int'(cnt_q) * S + t);
        mobius_stage_dyn #(
            .N      (N),
            .LOG2_N (LOG2_N),
            .KW     (KW)
        ) u_stage (
            .stage_k (k_t),
            .d_i     (chain[t]),
            .d_o     (chain[t+1])
        );
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_data  = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                data_d = chain[S];
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // A new vector may be taken in the same cycle the result leaves.
                if (out_ready) begin
                    if (accept) begin
                        data_d  = in_data;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_mobius_seq_inv.sv
// Bench for mobius_seq_inv: subset-sum reference model, per-cycle compare of the
// S=1 instance, directed latency/backpressure/reset cases, plus S=3 and N=8 instances.
module tb_mobius_seq_inv;

    localparam int N    = 512;
    localparam int AW   = 9;
    localparam int LAT1 = 10;
    localparam int LAT3 = 4;
    localparam int LAT8 = 4;

    typedef logic [0:N-1] vec_t;
    typedef logic [0:7]   vec8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic in_valid, in_ready, out_valid, out_ready, busy;
    vec_t in_data, out_data;
    logic in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    vec_t in_data3, out_data3;
    logic in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    vec8_t in_data8, out_data8;

    mobius_seq_inv #(.N(512), .LOG2_N(9), .S(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );
    mobius_seq_inv #(.N(512), .LOG2_N(9), .S(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .busy(busy3)
    );
    mobius_seq_inv #(.N(8), .LOG2_N(3), .S(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .busy(busy8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic chk_v8(input string name, input vec8_t act, input vec8_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    // Truth table value at x is the XOR of every ANF coefficient whose index is a submask of x.
    function automatic vec_t mobius_ref(input vec_t a);
        vec_t r;
        int   y;
        logic acc;
        r = '0;
        for (int x = 0; x < N; x++) begin
            acc = 1'b0;
            y   = x;
            while (1) begin
                acc ^= a[y[AW-1:0]];
                if (y == 0) break;
                y = (y - 1) & x;
            end
            r[x[AW-1:0]] = acc;
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v = '0;
        for (int w = 0; w < N / 32; w++) v = (v << 32) | vec_t'($urandom());
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the S=1 instance: one vector in flight, fixed busy time.
    int   m_left = 0;
    logic m_hold = 1'b0;
    vec_t m_exp  = '0;
    int   n_acc  = 0;
    logic m_rdy, m_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_hold = 1'b0;
            chk_bit("rst out_valid", out_valid, 1'b0);
            chk_bit("rst busy", busy, 1'b0);
            chk_bit("rst in_ready", in_ready, 1'b1);
            chk_vec("rst out_data", out_data, '0);
        end else begin
            m_rdy = (m_left == 0) && (!m_hold || out_ready);
            chk_bit("in_ready", in_ready, m_rdy);
            chk_bit("out_valid", out_valid, m_hold);
            chk_bit("busy", busy, m_left != 0);
            if (m_hold) chk_vec("out_data", out_data, m_exp);
            m_acc = in_valid && m_rdy;
            if (m_hold && out_ready) m_hold = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_hold = 1'b1;
            end
            if (m_acc) begin
                m_left = LAT1 - 1;
                m_exp  = mobius_ref(in_data);
                n_acc++;
            end
        end
    end

    task automatic measure_main(output int lat, output logic bm, output logic be);
        bm = 1'b1; be = 1'b1; lat = 99;
        for (int d = 1; d <= 40; d++) begin
            tick();
            if (d == 1) in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin lat = d; be = busy; break; end
            if (!busy) bm = 1'b0;
        end
    endtask

    task automatic run_main(input vec_t v, output vec_t res, output int lat);
        logic bm, be;
        tick();
        in_valid = 1'b1; in_data = v;
        @(negedge clk);
        chk_bit("main accept", in_ready, 1'b1);
        measure_main(lat, bm, be);
        chk_bit("main busy between", bm, 1'b1);
        chk_bit("main busy at done", be, 1'b0);
        res = out_data;
    endtask

    task automatic run3(input vec_t v, output vec_t res, output int lat);
        logic bm, be;
        tick();
        in_valid3 = 1'b1; in_data3 = v;
        @(negedge clk);
        chk_bit("s3 accept", in_ready3, 1'b1);
        bm = 1'b1; be = 1'b1; lat = 99;
        for (int d = 1; d <= 40; d++) begin
            tick();
            if (d == 1) in_valid3 = 1'b0;
            @(negedge clk);
            if (out_valid3) begin lat = d; be = busy3; break; end
            if (!busy3) bm = 1'b0;
        end
        chk_bit("s3 busy between", bm, 1'b1);
        chk_bit("s3 busy at done", be, 1'b0);
        res = out_data3;
    endtask

    task automatic run8(input string name, input vec8_t v, input vec8_t exp);
        int lat;
        tick();
        in_valid8 = 1'b1; in_data8 = v;
        @(negedge clk);
        chk_bit("n8 accept", in_ready8, 1'b1);
        lat = 99;
        for (int d = 1; d <= 40; d++) begin
            tick();
            if (d == 1) in_valid8 = 1'b0;
            @(negedge clk);
            if (out_valid8) begin lat = d; break; end
        end
        chk_int("n8 latency", lat, LAT8);
        chk_v8(name, out_data8, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e0, e1, e511, v, v1, v2, r, back, held;
        int   lat, target, cyc;
        logic bm, be;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        e0   = {1'b1, {(N-1){1'b0}}};
        e1   = {2'b01, {(N-2){1'b0}}};
        e511 = vec_t'(1);

        repeat (2) tick();
        @(negedge clk);
        chk_bit("rst s3 out_valid", out_valid3, 1'b0);
        chk_bit("rst s3 in_ready", in_ready3, 1'b1);
        chk_v8("rst n8 out_data", out_data8, 8'h00);
        tick();
        rst_n = 1'b1;

        chk_vec("model e0", mobius_ref(e0), '1);
        chk_vec("model e511", mobius_ref(e511), e511);
        chk_vec("model e1", mobius_ref(e1), {(N/2){2'b01}});

        run_main(e0, r, lat);
        chk_int("latency s1", lat, LAT1);
        chk_vec("e0 to ones", r, '1);

        for (int i = 0; i < 2; i++) begin
            v = rand_vec();
            run_main(v, r, lat);
            chk_vec("ref match", r, mobius_ref(v));
            run_main(r, back, lat);
            chk_vec("involution", back, v);
        end

        v1 = rand_vec(); v2 = rand_vec();
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = v1;
        @(negedge clk);
        chk_bit("bp accept", in_ready, 1'b1);
        measure_main(lat, bm, be);
        chk_int("bp latency", lat, LAT1);
        held = mobius_ref(v1);
        chk_vec("bp result", out_data, held);
        for (int c = 0; c < 5; c++) begin
            tick();
            in_valid = 1'b1; in_data = v2;
            @(negedge clk);
            chk_bit("bp in_ready low", in_ready, 1'b0);
            chk_bit("bp out_valid held", out_valid, 1'b1);
            chk_vec("bp data stable", out_data, held);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk_bit("handoff in_ready", in_ready, 1'b1);
        chk_bit("handoff out_valid", out_valid, 1'b1);
        measure_main(lat, bm, be);
        chk_int("handoff latency", lat, LAT1);
        chk_vec("handoff result", out_data, mobius_ref(v2));

        v = rand_vec();
        tick();
        in_valid = 1'b1; in_data = v;
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk_bit("pre rst busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("async rst out_valid", out_valid, 1'b0);
        chk_bit("async rst busy", busy, 1'b0);
        chk_bit("async rst in_ready", in_ready, 1'b1);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("post rst in_ready", in_ready, 1'b1);
        run_main(v, r, lat);
        chk_int("post rst latency", lat, LAT1);
        chk_vec("post rst result", r, mobius_ref(v));

        target = n_acc + 500;
        cyc = 0;
        while (n_acc < target && cyc < 20000) begin
            tick();
            cyc++;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rand_vec();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        chk_bit("random vectors accepted", n_acc >= target, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (15) tick();

        for (int i = 0; i < 3; i++) begin
            v = rand_vec();
            run3(v, r, lat);
            chk_int("s3 latency", lat, LAT3);
            chk_vec("s3 result", r, mobius_ref(v));
        end
        run3(r, back, lat);
        chk_vec("s3 involution", back, mobius_ref(r));

        run8("n8 idx0", 8'b1000_0000, 8'b1111_1111);
        run8("n8 idx7", 8'b0000_0001, 8'b0000_0001);
        run8("n8 idx1", 8'b0100_0000, 8'b0101_0101);
        run8("n8 idx0+1", 8'b1100_0000, 8'b1010_1010);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
